// File: rtl/serial_compare_if.sv
// rtl/serial_compare_if.sv - operand/result handshake bundle for serial_compare
interface serial_compare_if #(
  parameter int N = 16,
  parameter int K = 4
);
  localparam int C  = N / K;
  localparam int CW = $clog2(C) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  A;
  logic [N-1:0]  B;
  logic [1:0]    m;
  logic          out_valid;
  logic          out_ready;
  logic          g;
  logic          l;
  logic          e;
  logic          err;
  logic [CW-1:0] cycles;

  modport master (
    output in_valid, A, B, m, out_ready,
    input  in_ready, out_valid, g, l, e, err, cycles
  );

  modport slave (
    input  in_valid, A, B, m, out_ready,
    output in_ready, out_valid, g, l, e, err, cycles
  );
endinterface

// File: rtl/serial_compare.sv
// rtl/serial_compare.sv - chunk-serial magnitude/equality comparator, MSB chunk first
module serial_compare #(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_compare_if.slave bus
);
  localparam int C  = N / K;
  localparam int CW = $clog2(C) + 1;
  localparam int IW = (C > 1) ? $clog2(C) : 1;

  localparam logic [1:0]    M_UNS = 2'b00;
  localparam logic [1:0]    M_SGN = 2'b01;
  localparam logic [1:0]    M_EQ  = 2'b10;
  localparam logic [1:0]    M_RSV = 2'b11;
  localparam logic [IW-1:0] IDX_TOP = IW'(C - 1);
  localparam logic [CW-1:0] C_CW    = CW'(C);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d;
  logic [1:0]    m_q, m_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          g_q, g_d, l_q, l_d, e_q, e_d, err_q, err_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [K-1:0]  ca, cb;

  // Current chunk pair; signed mode flips the sign bits so the MSB chunk orders as unsigned
  always_comb begin
    ca = a_q[int'(idx_q)*K +: K];
    cb = b_q[int'(idx_q)*K +: K];
    if (m_q == M_SGN && idx_q == IDX_TOP) begin
      ca[K-1] = ~ca[K-1];
      cb[K-1] = ~cb[K-1];
    end
  end

  // Next-state and result logic; results exist only while in DONE
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    idx_d   = idx_q;
    g_d     = g_q;
    l_d     = l_q;
    e_d     = e_q;
    err_d   = err_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.A;
          b_d     = bus.B;
          m_d     = bus.m;
          idx_d   = IDX_TOP;
          state_d = RUN;
        end
      end
      RUN: begin
        if (ca != cb) begin
          state_d = DONE;
          g_d     = (m_q != M_EQ) && (ca > cb);
          l_d     = (m_q != M_EQ) && (ca < cb);
          e_d     = 1'b0;
          err_d   = (m_q == M_RSV);
          cyc_d   = C_CW - CW'(idx_q);
        end else if (idx_q == '0) begin
          state_d = DONE;
          g_d     = 1'b0;
          l_d     = 1'b0;
          e_d     = 1'b1;
          err_d   = (m_q == M_RSV);
          cyc_d   = C_CW;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          g_d     = 1'b0;
          l_d     = 1'b0;
          e_d     = 1'b0;
          err_d   = 1'b0;
          cyc_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= M_UNS;
      idx_q   <= '0;
      g_q     <= 1'b0;
      l_q     <= 1'b0;
      e_q     <= 1'b0;
      err_q   <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      idx_q   <= idx_d;
      g_q     <= g_d;
      l_q     <= l_d;
      e_q     <= e_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.g         = g_q;
  assign bus.l         = l_q;
  assign bus.e         = e_q;
  assign bus.err       = err_q;
  assign bus.cycles    = cyc_q;
endmodule

// File: tb/tb_serial_compare.sv
// tb/tb_serial_compare.sv - scoreboard bench for serial_compare
module tb_serial_compare;
  localparam int N  = 16;
  localparam int K  = 4;
  localparam int CW = $clog2(N / K) + 1;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;
  int   rise_cyc;
  logic prev_ov;

  typedef struct {
    logic          g;
    logic          l;
    logic          e;
    logic          err;
    logic [CW-1:0] cycles;
    int            acc;
    string         name;
  } exp_t;

  exp_t sb[$];

  serial_compare_if #(.N(N), .K(K)) bus ();

  serial_compare #(.N(N), .K(K)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every output handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && !prev_ov) rise_cyc = cyc;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got out_valid=1 want no result");
        end else begin
          exp_t x;
          x = sb.pop_front();
          chk({x.name, "_g"},   32'(bus.g),      32'(x.g));
          chk({x.name, "_l"},   32'(bus.l),      32'(x.l));
          chk({x.name, "_e"},   32'(bus.e),      32'(x.e));
          chk({x.name, "_err"}, 32'(bus.err),    32'(x.err));
          chk({x.name, "_cyc"}, 32'(bus.cycles), 32'(x.cycles));
          chk({x.name, "_lat"}, 32'(rise_cyc - x.acc), 32'(x.cycles));
        end
      end
    end
    prev_ov = bus.out_valid;
  end

  task automatic issue(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] md, input logic eg, input logic el, input logic ee,
                       input logic eerr, input int ecyc, input bit wait_done);
    int n;
    exp_t x;
    @(posedge clk); #1;
    bus.A = a; bus.B = b; bus.m = md; bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      total++; bad++;
      $display("FAIL %s_accept_timeout: got in_ready=0 want 1", name);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.A = ~a; bus.B = a ^ 16'h5A5A; bus.m = ~md;
    x.g = eg; x.l = el; x.e = ee; x.err = eerr; x.cycles = CW'(ecyc);
    x.acc = cyc; x.name = name;
    sb.push_back(x);
    if (wait_done) begin
      n = 0;
      while (sb.size() != 0 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      if (sb.size() != 0) begin
        total++; bad++;
        $display("FAIL %s_result_timeout: got pending=%0d want 0", name, sb.size());
        sb.delete();
      end
    end
  endtask

  initial begin
    int n;
    total = 0; bad = 0; cyc = 0; rise_cyc = 0; prev_ov = 1'b0;
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.m = '0; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_cycles",    32'(bus.cycles),    0);
    chk("rst_gle",       {29'd0, bus.g, bus.l, bus.e}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 1);

    issue("uns_lt",   16'h1234, 16'h1235, 2'b00, 0, 1, 0, 0, 4, 1);
    issue("uns_gt",   16'h8000, 16'h7FFF, 2'b00, 1, 0, 0, 0, 1, 1);
    issue("sgn_lt",   16'h8000, 16'h7FFF, 2'b01, 0, 1, 0, 0, 1, 1);
    issue("sgn_m1",   16'hFFFF, 16'h0001, 2'b01, 0, 1, 0, 0, 1, 1);
    issue("sgn_low",  16'hF000, 16'hF001, 2'b01, 0, 1, 0, 0, 4, 1);
    issue("eq_same",  16'hBEEF, 16'hBEEF, 2'b10, 0, 0, 1, 0, 4, 1);
    issue("eq_diff",  16'hBEEF, 16'hBEEE, 2'b10, 0, 0, 0, 0, 4, 1);
    issue("eq_early", 16'h1000, 16'h2000, 2'b10, 0, 0, 0, 0, 1, 1);
    issue("rsv_gt",   16'h0010, 16'h0001, 2'b11, 1, 0, 0, 1, 3, 1);
    issue("uns_eq",   16'h5A5A, 16'h5A5A, 2'b00, 0, 0, 1, 0, 4, 1);
    issue("uns_c2",   16'h0300, 16'h0200, 2'b00, 1, 0, 0, 0, 2, 1);

    // Backpressure: hold out_ready low for 3 cycles in DONE
    bus.out_ready = 1'b0;
    issue("bp", 16'h00A0, 16'h00B0, 2'b00, 0, 1, 0, 0, 3, 0);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(bus.out_valid), 1);
      chk("bp_in_ready",  32'(bus.in_ready),  0);
      chk("bp_gle",       {29'd0, bus.g, bus.l, bus.e}, 32'b010);
      chk("bp_cycles",    32'(bus.cycles), 3);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_after", 32'(bus.in_ready), 1);
    chk("bp_out_valid_after", 32'(bus.out_valid), 0);
    chk("bp_drained", 32'(sb.size()), 0);
    sb.delete();

    // Reset in the middle of RUN, after two chunk compares
    issue("rst_run", 16'h1234, 16'h1235, 2'b00, 0, 1, 0, 0, 4, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrun_out_valid", 32'(bus.out_valid), 0);
    chk("midrun_cycles",    32'(bus.cycles),    0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrun_in_ready", 32'(bus.in_ready), 1);
    repeat (8) begin
      @(negedge clk);
      chk("no_stale_result", 32'(bus.out_valid), 0);
    end

    issue("after_rst", 16'h0001, 16'h0000, 2'b00, 1, 0, 0, 0, 4, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
